// File: rtl/d_flip_flop_pkg.sv
// ============================================================================
// d_flip_flop_pkg : shared defaults for the d_flip_flop register slice
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package d_flip_flop_pkg;

    localparam int C_DEFAULT_WIDTH = 1;

    typedef logic bit_t;

    // True when a requested register width can actually be built.
    function automatic bit width_ok(input int width);
        return (width >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/d_flip_flop_if.sv
// ============================================================================
// d_flip_flop_if : D input and true/complement outputs of a d_flip_flop
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

interface d_flip_flop_if
    import d_flip_flop_pkg::*;
#(
    parameter int WIDTH = C_DEFAULT_WIDTH
) ();

    logic [WIDTH-1:0] data;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qb;

    modport master (
        output data,
        input  q,
        input  qb
    );

    modport slave (
        input  data,
        output q,
        output qb
    );

endinterface

`default_nettype wire

// File: rtl/dff_bit_cell.sv
// ============================================================================
// dff_bit_cell : single-bit rising-edge flop, async active-low reset to rv
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module dff_bit_cell
    import d_flip_flop_pkg::*;
(
    input  wire  clk,
    input  wire  rst,
    input  bit_t d,
    input  bit_t rv,
    output bit_t q,
    output bit_t qb
);

    bit_t state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= rv;
        end else begin
            state <= d;
        end
    end

    // Both outputs come from the one stored bit so they can never skew apart.
    assign q  = state;
    assign qb = ~state;

endmodule

`default_nettype wire

// File: rtl/d_flip_flop.sv
// ============================================================================
// d_flip_flop : WIDTH-bit D register with complementary outputs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module d_flip_flop
    import d_flip_flop_pkg::*;
#(
    parameter int               WIDTH   = C_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  wire           clk,
    input  wire           rst,
    d_flip_flop_if.slave  bus
);

    generate
        if (!width_ok(WIDTH)) begin : g_param_check
            $error("d_flip_flop: WIDTH must be at least 1");
        end
    endgenerate

    logic [WIDTH-1:0] q_vec;
    logic [WIDTH-1:0] qb_vec;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            dff_bit_cell u_cell (
                .clk (clk),
                .rst (rst),
                .d   (bus.data[i]),
                .rv  (RST_VAL[i]),
                .q   (q_vec[i]),
                .qb  (qb_vec[i])
            );
        end
    endgenerate

    assign bus.q  = q_vec;
    assign bus.qb = qb_vec;

endmodule

`default_nettype wire

// File: tb/tb_d_flip_flop.sv
// ============================================================================
// tb_d_flip_flop : scoreboard bench for 1-bit and 8-bit d_flip_flop instances
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_d_flip_flop;

    typedef struct {
        logic       q1;
        logic [7:0] q8;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic seen_reset = 1'b0;
    int   total  = 0;
    int   passed = 0;
    exp_t sb[$];

    d_flip_flop_if #(.WIDTH(1)) if1 ();
    d_flip_flop_if #(.WIDTH(8)) if8 ();

    d_flip_flop #(.WIDTH(1), .RST_VAL(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    d_flip_flop #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (if8)
    );

    always #10 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial $monitor("t=%0t rst=%b data1=%b q1=%b qb1=%b data8=%h q8=%h qb8=%h",
                     $time, rst, if1.data, if1.q, if1.qb, if8.data, if8.q, if8.qb);

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic chk_reset_now(input string tag);
        chk({tag, "_q1"},  {7'b0, if1.q},  8'h00);
        chk({tag, "_qb1"}, {7'b0, if1.qb}, 8'h01);
        chk({tag, "_q8"},  if8.q,  8'hA5);
        chk({tag, "_qb8"}, if8.qb, 8'h5A);
    endtask

    // Invariant between the true and complement outputs, sampled mid-cycle.
    always @(negedge clk) begin
        if (seen_reset) begin
            chk("inv1", {7'b0, if1.qb}, {7'b0, ~if1.q});
            chk("inv8", if8.qb, ~if8.q);
        end
    end

    task automatic pop_and_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 8'h00, 8'h01);
        end else begin
            e = sb.pop_front();
            chk({tag, "_q1"},  {7'b0, if1.q},  {7'b0, e.q1});
            chk({tag, "_qb1"}, {7'b0, if1.qb}, {7'b0, ~e.q1});
            chk({tag, "_q8"},  if8.q,  e.q8);
            chk({tag, "_qb8"}, if8.qb, ~e.q8);
        end
    endtask

    // One cycle: new data at negedge, optional rst change mid-cycle, check after posedge.
    task automatic step(input string tag, input logic d1, input logic [7:0] d8,
                        input logic rst_at_edge);
        exp_t e;
        @(negedge clk);
        if1.data = d1;
        if8.data = d8;
        if (rst_at_edge !== rst) begin
            #5;
            rst = rst_at_edge;
            #1;
            if (!rst) chk_reset_now({tag, "_async"});
        end
        e.q1 = rst_at_edge ? d1 : 1'b0;
        e.q8 = rst_at_edge ? d8 : 8'hA5;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_and_check(tag);
    endtask

    initial begin
        logic [11:0] stream;
        exp_t        e;
        stream   = 12'b1010_0110_1001;
        if1.data = 1'b0;
        if8.data = 8'h00;

        // Reset asserted between edges with no clock edge involved.
        #15;
        rst = 1'b0;
        #1;
        seen_reset = 1'b1;
        chk_reset_now("rst_async");
        step("rst_hold", 1'b1, 8'hFF, 1'b0);
        step("rst_release", 1'b1, 8'h3C, 1'b1);

        for (int i = 0; i < 12; i++) begin
            step($sformatf("stream%0d", i), stream[11-i], 8'(i * 37 + 5), 1'b1);
        end

        // Data toggles twice between edges; q must hold until the next edge.
        @(negedge clk);
        if1.data = 1'b0; if8.data = 8'h11;
        #3;
        if1.data = 1'b1; if8.data = 8'h22;
        #3;
        if1.data = 1'b0; if8.data = 8'h33;
        #1;
        chk("hold_q1", {7'b0, if1.q}, 8'h01);
        e.q1 = 1'b0;
        e.q8 = 8'h33;
        sb.push_back(e);
        @(posedge clk);
        #1;
        pop_and_check("hold_edge");

        step("xdata", 1'bx, 8'b0000_xxxx, 1'b1);

        // Reset pulled low mid-stream and held across three edges with data=1.
        step("pre_rst", 1'b1, 8'hC3, 1'b1);
        step("mid_rst0", 1'b1, 8'h0F, 1'b0);
        step("mid_rst1", 1'b1, 8'hF0, 1'b0);
        step("mid_rst2", 1'b1, 8'h99, 1'b0);
        step("post_rst", 1'b1, 8'h3C, 1'b1);
        step("final", 1'b0, 8'h5A, 1'b1);

        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
